// File: rtl/accum_calc_pkg.sv
// Shared opcodes, FSM encoding and error bit indices
// for the accumulator calculator.
package accum_calc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CLR  = 4'h1;
  localparam logic [3:0] OP_SET  = 4'h2;
  localparam logic [3:0] OP_RSV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_DIV  = 4'h7;
  localparam logic [3:0] OP_MOD  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_NOR  = 4'hD;
  localparam logic [3:0] OP_XNOR = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DIVIDE = 1'b1
  } state_t;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;

endpackage

// File: rtl/accum_calc_divider.sv
// Restoring sequential divider, one quotient bit per cycle.
// valid is high on the edge that commits the final step.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] count;
  logic [W-1:0]  quoReg;
  logic [W-1:0]  remReg;
  logic [W-1:0]  divReg;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          fits;

  // Next restoring step; outputs are the post-step values
  always_comb begin
    shifted   = {remReg, quoReg[W-1]};
    fits      = shifted >= {1'b0, divReg};
    diff      = shifted[W-1:0] - divReg;
    quotient  = {quoReg[W-2:0], fits};
    remainder = fits ? diff : shifted[W-1:0];
    valid     = (count == CW'(1));
  end

  // Operand latch and step/counter register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count  <= '0;
      quoReg <= '0;
      remReg <= '0;
      divReg <= '0;
    end else if (load) begin
      count  <= CW'(W);
      quoReg <= dividend;
      remReg <= '0;
      divReg <= divisor;
    end else if (count != '0) begin
      count  <= count - CW'(1);
      quoReg <= quotient;
      remReg <= remainder;
    end
  end

endmodule

// File: rtl/accum_calc.sv
// Accumulator calculator: opcode decode, result mux,
// Start/Ready/Done handshake and divide sequencing.
module accum_calc
  import accum_calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic [3:0]     OpCode,
  input  logic [W-1:0]   InputA,
  output logic           Ready,
  output logic           Done,
  output logic [2*W-1:0] Result,
  output logic [1:0]     Error
);

  state_t         state, nextState;
  logic [2*W-1:0] resultReg, nextResult;
  logic [1:0]     errorReg, nextError;
  logic           doneReg, nextDone;
  logic           isMod, nextIsMod;

  logic [W-1:0]   f;
  logic [W-1:0]   addRes, subRes;
  logic           addOvf, subOvf;
  logic [2*W-1:0] product;
  logic           accept;
  logic           divLoad;
  logic [W-1:0]   divQuo, divRem;
  logic           divValid;

  assign f      = resultReg[W-1:0];
  assign Ready  = (state == ST_IDLE);
  assign accept = Start & Ready;
  assign Result = resultReg;
  assign Error  = errorReg;
  assign Done   = doneReg;

  seq_divider #(.W(W)) uDiv (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (divLoad),
    .dividend  (f),
    .divisor   (InputA),
    .quotient  (divQuo),
    .remainder (divRem),
    .valid     (divValid)
  );

  // Arithmetic datapath on feedback and operand
  always_comb begin
    addRes  = f + InputA;
    subRes  = f - InputA;
    addOvf  = (f[W-1] == InputA[W-1]) &
              (addRes[W-1] != f[W-1]);
    subOvf  = (f[W-1] != InputA[W-1]) &
              (subRes[W-1] != f[W-1]);
    product = {{W{1'b0}}, f} * {{W{1'b0}}, InputA};
  end

  // Next-state, result mux and handshake control
  always_comb begin
    nextState  = state;
    nextResult = resultReg;
    nextError  = errorReg;
    nextDone   = 1'b0;
    nextIsMod  = isMod;
    divLoad    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          nextDone  = 1'b1;
          nextError = 2'b00;
          unique case (OpCode)
            OP_NOP, OP_RSV: ;
            OP_CLR: nextResult = '0;
            OP_SET: nextResult = '1;
            OP_ADD: begin
              nextResult = {{W{addRes[W-1]}}, addRes};
              nextError[ERR_OVF] = addOvf;
            end
            OP_SUB: begin
              nextResult = {{W{subRes[W-1]}}, subRes};
              nextError[ERR_OVF] = subOvf;
            end
            OP_MUL: nextResult = product;
            OP_DIV, OP_MOD: begin
              if (InputA == '0) begin
                nextError[ERR_DIV0] = 1'b1;
              end else begin
                nextDone  = 1'b0;
                divLoad   = 1'b1;
                nextIsMod = (OpCode == OP_MOD);
                nextState = ST_DIVIDE;
              end
            end
            OP_AND:
              nextResult = {{W{1'b0}}, f & InputA};
            OP_OR:
              nextResult = {{W{1'b0}}, f | InputA};
            OP_XOR:
              nextResult = {{W{1'b0}}, f ^ InputA};
            OP_NAND:
              nextResult = {{W{1'b0}}, ~(f & InputA)};
            OP_NOR:
              nextResult = {{W{1'b0}}, ~(f | InputA)};
            OP_XNOR:
              nextResult = {{W{1'b0}}, ~(f ^ InputA)};
            OP_NOT: nextResult = ~resultReg;
            default: ;
          endcase
        end
      end
      ST_DIVIDE: begin
        if (divValid) begin
          nextResult = {{W{1'b0}}, isMod ? divRem : divQuo};
          nextError  = 2'b00;
          nextDone   = 1'b1;
          nextState  = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Accumulator, error, done and state registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      resultReg <= '0;
      errorReg  <= 2'b00;
      doneReg   <= 1'b0;
      isMod     <= 1'b0;
    end else begin
      state     <= nextState;
      resultReg <= nextResult;
      errorReg  <= nextError;
      doneReg   <= nextDone;
      isMod     <= nextIsMod;
    end
  end

endmodule

// File: tb/tb_accum_calc.sv
// Scoreboard bench for accum_calc (W=16) plus a
// short divide-latency run on a W=8 instance.
module tb_accum_calc;
  import accum_calc_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, Start;
  logic [3:0]  OpCode;
  logic [15:0] InputA;
  logic        Ready, Done;
  logic [31:0] Result;
  logic [1:0]  Error;

  logic        Rst8, Start8;
  logic [3:0]  OpCode8;
  logic [7:0]  InputA8;
  logic        Ready8, Done8;
  logic [15:0] Result8;
  logic [1:0]  Error8;

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int doneSeen = 0;
  logic [33:0] expQ[$];

  accum_calc #(.W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .OpCode(OpCode), .InputA(InputA),
    .Ready(Ready), .Done(Done),
    .Result(Result), .Error(Error)
  );

  accum_calc #(.W(8)) dut8 (
    .Clk(Clk), .Rst(Rst8), .Start(Start8),
    .OpCode(OpCode8), .InputA(InputA8),
    .Ready(Ready8), .Done(Done8),
    .Result(Result8), .Error(Error8)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst && Done) begin
      doneSeen++;
      if (expQ.size() == 0) begin
        check("spurious Done", 64'(Done), 64'd0);
      end else begin
        logic [33:0] e;
        e = expQ.pop_front();
        check("Result", 64'(Result), 64'(e[33:2]));
        check("Error", 64'(Error), 64'(e[1:0]));
      end
    end
  end

  task automatic op(input logic [3:0] opc,
                    input logic [15:0] a,
                    input logic [31:0] expR,
                    input logic [1:0] expE,
                    input int expLat);
    int n;
    expQ.push_back({expR, expE});
    pushed++;
    Start = 1'b1;
    OpCode = opc;
    InputA = a;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0;
    while (!Ready && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(expLat));
  endtask

  initial begin
    int n;
    Rst = 1'b1; Start = 1'b0;
    OpCode = OP_NOP; InputA = '0;
    Rst8 = 1'b1; Start8 = 1'b0;
    OpCode8 = OP_NOP; InputA8 = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("rst Result", 64'(Result), 64'd0);
    check("rst Ready", 64'(Ready), 64'd1);
    check("rst Done", 64'(Done), 64'd0);
    check("rst Error", 64'(Error), 64'd0);

    op(OP_ADD, 16'd2, 32'd2, 2'b00, 0);
    op(OP_MUL, 16'd5, 32'd10, 2'b00, 0);
    op(OP_MUL, 16'd314, 32'd3140, 2'b00, 0);
    op(OP_DIV, 16'd100, 32'd31, 2'b00, 16);
    op(OP_CLR, 16'd0, 32'd0, 2'b00, 0);
    op(OP_ADD, 16'd3140, 32'd3140, 2'b00, 0);
    op(OP_SUB, 16'd100, 32'd3040, 2'b00, 0);
    op(OP_MOD, 16'd100, 32'd40, 2'b00, 16);

    op(OP_CLR, 16'd0, 32'd0, 2'b00, 0);
    op(OP_ADD, 16'd7, 32'd7, 2'b00, 0);
    op(OP_DIV, 16'd0, 32'd7, 2'b10, 0);
    op(OP_ADD, 16'd1, 32'd8, 2'b00, 0);

    op(OP_CLR, 16'd0, 32'd0, 2'b00, 0);
    op(OP_ADD, 16'h7FFF, 32'h0000_7FFF, 2'b00, 0);
    op(OP_ADD, 16'h0001, 32'hFFFF_8000, 2'b01, 0);
    op(OP_SUB, 16'h0001, 32'h0000_7FFF, 2'b01, 0);
    op(OP_CLR, 16'd0, 32'd0, 2'b00, 0);
    op(OP_SET, 16'd0, 32'hFFFF_FFFF, 2'b00, 0);
    op(OP_NOT, 16'd0, 32'd0, 2'b00, 0);

    op(OP_SET, 16'd0, 32'hFFFF_FFFF, 2'b00, 0);
    op(OP_AND, 16'h0F0F, 32'h0000_0F0F, 2'b00, 0);
    op(OP_XOR, 16'hFFFF, 32'h0000_F0F0, 2'b00, 0);
    op(OP_NOR, 16'h000F, 32'h0000_0F00, 2'b00, 0);
    op(OP_NAND, 16'h0F00, 32'h0000_F0FF, 2'b00, 0);
    op(OP_NOP, 16'h1234, 32'h0000_F0FF, 2'b00, 0);
    op(OP_RSV, 16'h1234, 32'h0000_F0FF, 2'b00, 0);

    op(OP_CLR, 16'd0, 32'd0, 2'b00, 0);
    op(OP_ADD, 16'd3140, 32'd3140, 2'b00, 0);
    expQ.push_back({32'd31, 2'b00});
    pushed++;
    Start = 1'b1;
    OpCode = OP_DIV;
    InputA = 16'd100;
    @(posedge Clk); #1;
    n = 0;
    while (!Ready && n < 40) begin
      OpCode = n[0] ? OP_CLR : OP_ADD;
      InputA = 16'(n + 1);
      check("hold in div", 64'(Result), 64'd3140);
      @(posedge Clk); #1;
      n++;
    end
    Start = 1'b0;
    check("busy latency", 64'(n), 64'd16);
    repeat (3) @(posedge Clk);
    #1;

    Rst = 1'b1;
    Start = 1'b1;
    OpCode = OP_ADD;
    InputA = 16'd5;
    @(posedge Clk); #1;
    Rst = 1'b0;
    Start = 1'b0;
    check("rst+start Result", 64'(Result), 64'd0);
    check("rst+start Done", 64'(Done), 64'd0);
    @(posedge Clk); #1;
    check("rst+start later", 64'(Result), 64'd0);

    op(OP_ADD, 16'd3140, 32'd3140, 2'b00, 0);
    Start = 1'b1;
    OpCode = OP_DIV;
    InputA = 16'd100;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    check("mid-div Ready", 64'(Ready), 64'd0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("mid-rst Result", 64'(Result), 64'd0);
    check("mid-rst Ready", 64'(Ready), 64'd1);
    check("mid-rst Done", 64'(Done), 64'd0);
    check("mid-rst Error", 64'(Error), 64'd0);
    repeat (25) @(posedge Clk);
    #1;
    check("no late write", 64'(Result), 64'd0);
    check("idle Ready", 64'(Ready), 64'd1);

    check("queue drained", 64'(expQ.size()), 64'd0);
    check("Done count", 64'(doneSeen), 64'(pushed));

    Rst8 = 1'b0;
    Start8 = 1'b1;
    OpCode8 = OP_ADD;
    InputA8 = 8'd100;
    @(posedge Clk); #1;
    Start8 = 1'b0;
    check("w8 add", 64'(Result8), 64'd100);
    check("w8 add Done", 64'(Done8), 64'd1);
    Start8 = 1'b1;
    OpCode8 = OP_DIV;
    InputA8 = 8'd7;
    @(posedge Clk); #1;
    Start8 = 1'b0;
    n = 0;
    while (!Ready8 && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    check("w8 latency", 64'(n), 64'd8);
    check("w8 div", 64'(Result8), 64'd14);
    check("w8 div Done", 64'(Done8), 64'd1);
    check("w8 div Error", 64'(Error8), 64'd0);
    @(posedge Clk); #1;
    check("w8 Done pulse", 64'(Done8), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/accum_calc.md
# accum_calc

Parametrised accumulator calculator: a 2·W-bit accumulator register updated by one of 16 opcoded operations applied to the accumulator's low W bits and a W-bit input operand. It is the next generation of the team's 16-bit accumulator breadboard, with these additions:
- operand width is a parameter;
- reset is synchronous;
- a Start/Ready/Done handshake;
- a multi-cycle sequential divider for DIV/MOD in place of single-cycle combinational division.

It sits between the stimulus/control logic and the Result display path.

## Interface
- W, 16, operand width; accumulator and Result are 2·W bits; W ≥ 2.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset; synchronous, active-high.
- Start  in  1  request; an operation is accepted on the edge where Start & Ready.
- OpCode  in  4  operation select, sampled at accept.
- InputA  in  W  operand, sampled at accept.
- Ready  out  1  high in IDLE; low while a division is in progress.
- Done  out  1  one-cycle pulse in the cycle after an accepted operation's result is written.
- Result  out  2·W  accumulator contents, registered.
- Error  out  2  [0] signed add/sub overflow, [1] divide by zero; registered.

## Operation
- Definitions:
  - F = Result[W-1:0], the feedback.
  - A = InputA latched at accept.
  - "Hold" means Result is unchanged.
- Opcodes:
  - 0000 NOP: hold.
  - 0001 CLR: Result=0.
  - 0010 SET: Result=all ones.
  - 0011: reserved; hold.
  - 0100 ADD: F+A.
  - 0101 SUB: F−A.
  - 0110 MUL: F·A.
  - 0111 DIV: F/A.
  - 1000 MOD: F%A.
  - 1001 AND, 1010 OR, 1011 XOR, 1100 NAND, 1101 NOR, 1110 XNOR: bitwise on F and A.
  - 1111 NOT: ~Result, full 2·W bits.
- Width rules:
  - ADD/SUB: W-bit two's-complement result, sign-extended to 2·W.
  - MUL: unsigned, full 2·W-bit product.
  - DIV/MOD: unsigned, quotient/remainder zero-extended.
  - Logical ops: upper W bits forced to 0.
- Error update: Error is rewritten on every completed operation.
  - Error[0] = signed overflow (carry into MSB XOR carry out), ADD/SUB only; 0 otherwise.
  - Error[1] = (A==0), DIV/MOD only; 0 otherwise.
  - Errors are not sticky.
- Divide by zero: Result holds, Error=10, and the operation completes as a single-cycle operation (no DIVIDE state).
- State machine, IDLE ↔ DIVIDE:
  - IDLE, accept of DIV/MOD with A≠0: latch F and A, load counter with W, go to DIVIDE.
  - DIVIDE: one restoring shift/subtract step per cycle; counter decrements.
  - On the step where counter hits 0: write the quotient (DIV) or remainder (MOD) to Result, go to IDLE.
  - All other accepted opcodes complete in IDLE without a state change.
- Busy behaviour: Start while Ready=0 is ignored and is not queued. InputA and OpCode changes during DIVIDE have no effect.
- Rst, including mid-division: state=IDLE, counter=0, Result=0, Error=00, Done=0, Ready=1 in the cycle after the reset edge. An in-flight division is discarded.
- Rst and Start on the same edge: Rst wins and the request is dropped.

## Timing
- Single-cycle operations: accept on edge E0; Result/Error show the new value and Done=1 during the cycle E0→E1. Ready stays high, so back-to-back accepts on consecutive edges are legal.
- DIV/MOD (A≠0): accept on E0; Ready=0 from E0 to E_W. Result is written at E_W; Done=1 and Ready=1 during E_W→E_W+1. Latency is W cycles.
- Done is 0 in every cycle not immediately following a completion edge.

## Structure
- Shared package holds:
  - the 4-bit opcode constants (OP_NOP … OP_NOT);
  - the state encoding (ST_IDLE, ST_DIVIDE);
  - error bit indices (ERR_OVF=0, ERR_DIV0=1).
- One sub-module, seq_divider (parameter W):
  - inputs: Clk, Rst, load, dividend, divisor;
  - outputs: quotient, remainder, valid pulse.
  - accum_calc owns the handshake, the opcode decode/result mux and the accumulator register.

## Test plan
- Rst, then ADD 2, MUL 5, MUL 314: Result=3140, Error=00, Done pulses once per op, Ready never drops.
- From 3140, DIV 100 (W=16): Ready low for 16 cycles, then Result=31 with a single Done pulse. CLR, ADD 3140, SUB 100, MOD 100 → Result=40.
- DIV 0 with Result=7: Result stays 7, Error=10, Done after 1 cycle. Next ADD 1 → Result=8, Error=00.
- From CLR, ADD 0x7FFF, then ADD 1: Result=0xFFFF8000, Error=01. CLR, SET, NOT → Result=0.
- Start held high with alternating opcodes during a division: ignored. Result changes only at E_16 to the DIV value.
- Assert Rst at cycle 5 of a division: next cycle Result=0, Ready=1, Done=0, and no late write occurs afterwards. Repeat with W=8: DIV latency is 8 cycles.
